// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor: pulses pll_rst, qualifies locked, retries and flags lock loss.
// Build macro PLL_SUP_AUTO_RELOCK_EN: lock loss in RUN restarts the sequence instead of latching FAIL.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 74250,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int DROP_FILTER   = 4
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       pll_ready,
  output logic       lock_lost,
  output logic       pll_fail,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  localparam int MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_B = (SETTLE_CYCLES > DROP_FILTER) ? SETTLE_CYCLES : DROP_FILTER;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DROP_LAST   = CNT_W'(DROP_FILTER - 1);
  localparam logic [1:0]       RETRY_MAX   = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       retry_q, retry_d;
  logic [1:0]       sync_q, sync_d;
  logic             pll_rst_q, pll_rst_d;
  logic             pll_ready_q, pll_ready_d;
  logic             lock_lost_q, lock_lost_d;
  logic             pll_fail_q, pll_fail_d;
  logic             locked_s;

  assign locked_s = sync_q[1];

  always_comb begin
    sync_d      = {sync_q[0], pll_locked};
    state_d     = state_q;
    cnt_d       = cnt_q;
    retry_d     = retry_q;
    lock_lost_d = lock_lost_q;
    if (restart) begin
      state_d     = ST_RESET;
      retry_d     = '0;
      lock_lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
          else                   cnt_d   = cnt_q + CNT_W'(1);
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_d = ST_SETTLE;
          end else if (cnt_q == TMO_LAST) begin
            if (retry_q == RETRY_MAX) begin
              state_d = ST_FAIL;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = ST_RESET;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (!locked_s)                 state_d = ST_WAIT_LOCK;
          else if (cnt_q == SETTLE_LAST) state_d = ST_RUN;
          else                           cnt_d   = cnt_q + CNT_W'(1);
        end
        ST_RUN: begin
          // Counter here is the length of the current unlocked streak.
          if (locked_s) begin
            cnt_d = '0;
          end else if (cnt_q == DROP_LAST) begin
            lock_lost_d = 1'b1;
`ifdef PLL_SUP_AUTO_RELOCK_EN
            retry_d = '0;
            state_d = ST_RESET;
`else
            state_d = ST_FAIL;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_FAIL: begin
          state_d = ST_FAIL;
        end
        default: state_d = ST_RESET;
      endcase
    end
    // A restart or any state change begins a fresh count.
    if (restart || (state_d != state_q)) cnt_d = '0;
    pll_rst_d   = (state_d == ST_RESET) || (state_d == ST_FAIL);
    pll_ready_d = (state_d == ST_RUN);
    pll_fail_d  = (state_d == ST_FAIL);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      state_q     <= ST_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      pll_ready_q <= 1'b0;
      lock_lost_q <= 1'b0;
      pll_fail_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      pll_ready_q <= pll_ready_d;
      lock_lost_q <= lock_lost_d;
      pll_fail_q  <= pll_fail_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign pll_ready = pll_ready_q;
  assign lock_lost = lock_lost_q;
  assign pll_fail  = pll_fail_q;
  assign retry_cnt = retry_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed sequences then random lock/restart/reset traffic,
// every cycle compared against a phase/duration model of the supervisor.
module tb_pll_lock_supervisor;

  localparam int RST_CYCLES    = 4;
  localparam int LOCK_TIMEOUT  = 20;
  localparam int SETTLE_CYCLES = 8;
  localparam int MAX_RETRIES   = 2;
  localparam int DROP_FILTER   = 3;
`ifdef PLL_SUP_AUTO_RELOCK_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst, restart, pll_locked;
  logic       pll_rst, pll_ready, lock_lost, pll_fail;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // Reference model: phase number (0 RESET .. 4 FAIL), time spent in the phase / streak length.
  int m_st, m_t, m_retry;
  bit m_lost, m_s0, m_s1;

  pll_lock_supervisor #(
    .RST_CYCLES(RST_CYCLES), .LOCK_TIMEOUT(LOCK_TIMEOUT), .SETTLE_CYCLES(SETTLE_CYCLES),
    .MAX_RETRIES(MAX_RETRIES), .DROP_FILTER(DROP_FILTER)
  ) dut (
    .refclk(refclk), .rst(rst), .restart(restart), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .pll_ready(pll_ready), .lock_lost(lock_lost), .pll_fail(pll_fail),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #5 refclk = ~refclk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void m_go(input int s);
    m_st = s;
    m_t  = 0;
  endfunction

  function automatic void model_reset();
    m_go(0);
    m_retry = 0;
    m_lost  = 1'b0;
    m_s0    = 1'b0;
    m_s1    = 1'b0;
  endfunction

  // One refclk edge of the supervisor as described behaviourally.
  task automatic model_step();
    bit ls;
    ls   = m_s1;
    m_s1 = m_s0;
    m_s0 = pll_locked;
    if (restart) begin
      m_go(0);
      m_retry = 0;
      m_lost  = 1'b0;
    end else begin
      case (m_st)
        0: begin
          m_t++;
          if (m_t == RST_CYCLES) m_go(1);
        end
        1: begin
          if (ls) m_go(2);
          else begin
            m_t++;
            if (m_t == LOCK_TIMEOUT) begin
              if (m_retry == MAX_RETRIES) m_go(4);
              else begin
                m_retry++;
                m_go(0);
              end
            end
          end
        end
        2: begin
          if (!ls) m_go(1);
          else begin
            m_t++;
            if (m_t == SETTLE_CYCLES) m_go(3);
          end
        end
        3: begin
          if (ls) m_t = 0;
          else    m_t++;
          if (m_t == DROP_FILTER) begin
            m_lost = 1'b1;
            if (AUTO) begin
              m_retry = 0;
              m_go(0);
            end else begin
              m_go(4);
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    chk_eq("state",     state,     m_st);
    chk_eq("pll_rst",   pll_rst,   (m_st == 0) || (m_st == 4));
    chk_eq("pll_ready", pll_ready, m_st == 3);
    chk_eq("pll_fail",  pll_fail,  m_st == 4);
    chk_eq("lock_lost", lock_lost, m_lost);
    chk_eq("retry_cnt", retry_cnt, m_retry);
  endtask

  task automatic tick();
    @(posedge refclk);
    if (rst) model_reset();
    else     model_step();
    #1;
    check_all();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_state(input string tag, input int s, input int limit, output int n);
    n = 0;
    while ((state !== 3'(s)) && (n < limit)) begin
      tick();
      n++;
    end
    chk_eq(tag, state, s);
  endtask

  initial begin
    int n, hold;
    rst = 1'b1;
    restart = 1'b0;
    pll_locked = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;

    // Power-up: pll_rst held for RST_CYCLES edges, then WAIT_LOCK.
    repeat (RST_CYCLES - 1) tick();
    chk_eq("por_rst_hold", pll_rst, 1);
    tick();
    chk_eq("por_wait_state", state, 1);
    chk_eq("por_rst_release", pll_rst, 0);
    repeat (6) tick();

    // pll_ready rises on the 11th edge counting the one that first samples pll_locked.
    pll_locked = 1'b1;
    n = 0;
    while (!pll_ready && n < 30) begin
      tick();
      n++;
    end
    chk_eq("ready_latency", n, 11);
    chk_eq("run_state", state, 3);

    // Drop filter: a 2-cycle drop is ignored, a 3-cycle drop is lock loss.
    pll_locked = 1'b0;
    repeat (2) tick();
    pll_locked = 1'b1;
    repeat (4) tick();
    chk_eq("short_drop_ready", pll_ready, 1);
    pll_locked = 1'b0;
    n = 0;
    while (!lock_lost && n < 10) begin
      tick();
      n++;
    end
    chk_eq("loss_flag", lock_lost, 1);
    chk_eq("loss_ready", pll_ready, 0);
    chk_eq("loss_state", state, AUTO ? 0 : 4);
    chk_eq("loss_fail", pll_fail, AUTO ? 0 : 1);

    // Restart clears everything, then three timeouts exhaust the retries.
    pulse_restart();
    chk_eq("rs_state", state, 0);
    chk_eq("rs_fail", pll_fail, 0);
    chk_eq("rs_lost", lock_lost, 0);
    chk_eq("rs_retry", retry_cnt, 0);
    repeat (RST_CYCLES + LOCK_TIMEOUT) tick();
    chk_eq("tmo1_retry", retry_cnt, 1);
    chk_eq("tmo1_state", state, 0);
    repeat (2 * (RST_CYCLES + LOCK_TIMEOUT)) tick();
    chk_eq("tmo3_state", state, 4);
    chk_eq("tmo3_fail", pll_fail, 1);
    chk_eq("tmo3_rst", pll_rst, 1);
    chk_eq("tmo3_retry", retry_cnt, 2);
    pulse_restart();
    chk_eq("fail_rs_state", state, 0);
    chk_eq("fail_rs_fail", pll_fail, 0);
    chk_eq("fail_rs_retry", retry_cnt, 0);

    // Restart coinciding with the second timeout wins.
    repeat (2 * RST_CYCLES + 2 * LOCK_TIMEOUT - 1) tick();
    chk_eq("pre_tmo_state", state, 1);
    chk_eq("pre_tmo_retry", retry_cnt, 1);
    pulse_restart();
    chk_eq("rs_tmo_state", state, 0);
    chk_eq("rs_tmo_retry", retry_cnt, 0);

    // Settle glitch: one low cycle at settle count 5 sends it back to WAIT_LOCK.
    pll_locked = 1'b1;
    wait_state("reach_settle", 2, 40, n);
    repeat (5) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    wait_state("glitch_wait", 1, 10, n);
    chk_eq("glitch_retry", retry_cnt, 0);
    wait_state("glitch_run", 3, 30, n);
    chk_eq("glitch_run_latency", n, SETTLE_CYCLES + 1);

    // Asynchronous reset in the middle of SETTLE.
    pulse_restart();
    wait_state("reach_settle2", 2, 40, n);
    repeat (3) tick();
    rst = 1'b1;
    #2;
    model_reset();
    chk_eq("arst_state", state, 0);
    chk_eq("arst_rst", pll_rst, 1);
    chk_eq("arst_ready", pll_ready, 0);
    check_all();
    tick();
    rst = 1'b0;
    wait_state("arst_rerun", 3, 60, n);

    // Random traffic: long lock/unlock runs, occasional restarts and resets.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        pll_locked = ($urandom_range(0, 3) != 0);
        hold = (pll_locked && $urandom_range(0, 1) == 1) ? $urandom_range(20, 60)
                                                          : $urandom_range(1, 6);
      end
      hold--;
      restart = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 799) == 0) async_reset();
      else tick();
    end
    restart = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
